// File: rtl/maze_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : maze_mem_arbiter
// Purpose  : Single-port 256x1 maze map RAM arbiter. The loader has top
//            priority, and the solver and viewer share the port round-robin.
//            The solver may hold a bounded lock on the port.
// Revision : 1.0  initial release
// ============================================================================
module maze_mem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 1,
    parameter int LOCK_MAX = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              l_req,
    input  logic              s_req,
    input  logic              v_req,
    input  logic              l_we,
    input  logic              s_we,
    input  logic              v_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [ADDR_W-1:0] v_addr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] v_wdata,
    input  logic              s_lock,
    output logic              l_gnt,
    output logic              s_gnt,
    output logic              v_gnt,
    output logic              l_rvalid,
    output logic              s_rvalid,
    output logic              v_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lock_err
);

    localparam int c_CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_L    = 2'd1,
        TAG_S    = 2'd2,
        TAG_V    = 2'd3
    } tag_t;

    lock_state_t        r_state;
    lock_state_t        w_state_nxt;
    logic [c_CNT_W-1:0] r_lcnt;
    logic [c_CNT_W-1:0] w_lcnt_nxt;
    logic [c_CNT_W-1:0] w_lcnt_inc;
    logic               w_break;
    logic               r_rr;
    logic               r_lock_err;
    tag_t               r_tag;

    assign w_lcnt_inc = r_lcnt + c_CNT_W'(1);

    always_comb begin
        l_gnt = l_req;
        s_gnt = 1'b0;
        v_gnt = 1'b0;
        if (!l_req) begin
            if (r_state == ST_LOCKED && s_req) begin
                s_gnt = 1'b1;
            end else if (s_req && v_req) begin
                s_gnt = ~r_rr;
                v_gnt = r_rr;
            end else begin
                s_gnt = s_req;
                v_gnt = v_req;
            end
        end
    end

    always_comb begin
        mem_en    = l_gnt | s_gnt | v_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (l_gnt) begin
            mem_we    = l_we;
            mem_addr  = l_addr;
            mem_wdata = l_wdata;
        end else if (s_gnt) begin
            mem_we    = s_we;
            mem_addr  = s_addr;
            mem_wdata = s_wdata;
        end else if (v_gnt) begin
            mem_we    = v_we;
            mem_addr  = v_addr;
            mem_wdata = v_wdata;
        end
    end

    // A loader grant leaves the lock and its count untouched.
    always_comb begin
        w_state_nxt = r_state;
        w_lcnt_nxt  = r_lcnt;
        w_break     = 1'b0;
        case (r_state)
            ST_UNLOCKED: begin
                if (s_gnt && s_lock) begin
                    w_state_nxt = ST_LOCKED;
                    w_lcnt_nxt  = c_CNT_W'(1);
                end
            end
            ST_LOCKED: begin
                if (!s_lock || !s_req) begin
                    w_state_nxt = ST_UNLOCKED;
                    w_lcnt_nxt  = '0;
                end else if (s_gnt) begin
                    if (w_lcnt_inc == c_CNT_W'(LOCK_MAX)) begin
                        w_state_nxt = ST_UNLOCKED;
                        w_lcnt_nxt  = '0;
                        w_break     = 1'b1;
                    end else begin
                        w_lcnt_nxt = w_lcnt_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_UNLOCKED;
                w_lcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= ST_UNLOCKED;
            r_lcnt     <= '0;
            r_rr       <= 1'b0;
            r_lock_err <= 1'b0;
            r_tag      <= TAG_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_lcnt     <= w_lcnt_nxt;
            r_lock_err <= w_break;
            // A forced release hands the next contested slot to the viewer.
            if (w_break || s_gnt) begin
                r_rr <= 1'b1;
            end else if (v_gnt) begin
                r_rr <= 1'b0;
            end
            if (mem_en && !mem_we) begin
                r_tag <= l_gnt ? TAG_L : (s_gnt ? TAG_S : TAG_V);
            end else begin
                r_tag <= TAG_NONE;
            end
        end
    end

    assign l_rvalid = (r_tag == TAG_L);
    assign s_rvalid = (r_tag == TAG_S);
    assign v_rvalid = (r_tag == TAG_V);
    assign rdata    = (r_tag != TAG_NONE) ? mem_rdata : '0;
    assign lock_err = r_lock_err;

endmodule
`default_nettype wire
